// File: rtl/uart_frame_ctrl.sv
// Host command frame controller behind uart_rx: parses SYNC/ADDR/LEN/payload/CSUM
// frames, then drains the verified payload as register-bus writes.
module uart_frame_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 26040,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic       i_Wr_Ready,
    output logic       o_Frame_Done,
    output logic       o_Err_Csum,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Overrun,
    output logic       o_Busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_t;

    state_t        state;
    logic [7:0]    base_addr;
    logic [7:0]    csum;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [LW-1:0] idx_next;
    logic [TW-1:0] timer;
    logic          active;
    logic          timer_expired;
    logic [7:0]    payload_buf [0:(1<<IW)-1];

    assign idx_next      = idx + LW'(1);
    assign active        = (state == ADDR) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timer_expired = active && !i_Rx_DV && (timer == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock) begin
        if (state == PAYLOAD && i_Rx_DV) begin
            payload_buf[idx[IW-1:0]] <= i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state         <= IDLE;
            base_addr     <= '0;
            csum          <= '0;
            len           <= '0;
            idx           <= '0;
            timer         <= '0;
            o_Wr_En       <= 1'b0;
            o_Wr_Addr     <= '0;
            o_Wr_Data     <= '0;
            o_Frame_Done  <= 1'b0;
            o_Err_Csum    <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Overrun     <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Frame_Done  <= 1'b0;
            o_Err_Csum    <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Overrun     <= 1'b0;

            if (timer_expired) begin
                o_Err_Timeout <= 1'b1;
                state         <= IDLE;
                o_Busy        <= 1'b0;
                timer         <= '0;
            end else begin
                if (active) begin
                    timer <= i_Rx_DV ? '0 : timer + TW'(1);
                end

                case (state)
                    IDLE: begin
                        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                            state  <= ADDR;
                            csum   <= '0;
                            idx    <= '0;
                            timer  <= '0;
                            o_Busy <= 1'b1;
                        end
                    end

                    ADDR: begin
                        if (i_Rx_DV) begin
                            base_addr <= i_Rx_Byte;
                            csum      <= csum ^ i_Rx_Byte;
                            state     <= LEN;
                        end
                    end

                    LEN: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == 8'd0 || i_Rx_Byte > 8'(MAX_LEN)) begin
                                o_Err_Len <= 1'b1;
                                state     <= IDLE;
                                o_Busy    <= 1'b0;
                            end else begin
                                len   <= i_Rx_Byte[LW-1:0];
                                csum  <= csum ^ i_Rx_Byte;
                                idx   <= '0;
                                state <= PAYLOAD;
                            end
                        end
                    end

                    PAYLOAD: begin
                        if (i_Rx_DV) begin
                            csum <= csum ^ i_Rx_Byte;
                            idx  <= idx_next;
                            if (idx_next == len) begin
                                state <= CSUM;
                            end
                        end
                    end

                    CSUM: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == csum) begin
                                state     <= DRAIN;
                                idx       <= '0;
                                o_Wr_En   <= 1'b1;
                                o_Wr_Addr <= base_addr;
                                o_Wr_Data <= payload_buf[0];
                            end else begin
                                o_Err_Csum <= 1'b1;
                                state      <= IDLE;
                                o_Busy     <= 1'b0;
                            end
                        end
                    end

                    // Incoming bytes cannot be buffered while draining, so they are dropped.
                    DRAIN: begin
                        o_Overrun <= i_Rx_DV;
                        if (o_Wr_En && i_Wr_Ready) begin
                            if (idx_next == len) begin
                                o_Wr_En      <= 1'b0;
                                o_Frame_Done <= 1'b1;
                                state        <= IDLE;
                                o_Busy       <= 1'b0;
                            end else begin
                                idx       <= idx_next;
                                o_Wr_Addr <= base_addr + 8'(idx_next);
                                o_Wr_Data <= payload_buf[idx_next[IW-1:0]];
                            end
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        o_Wr_En <= 1'b0;
                        o_Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: table of frames plus hand-written
// backpressure, overrun, reset and timeout sequences, writes checked via a scoreboard.
module tb_uart_frame_ctrl;

    localparam int MAX_LEN      = 16;
    localparam int TIMEOUT_CLKS = 26040;

    logic       i_Clock = 1'b0;
    logic       i_Rst;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Wr_En;
    logic [7:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic       i_Wr_Ready;
    logic       o_Frame_Done;
    logic       o_Err_Csum;
    logic       o_Err_Len;
    logic       o_Err_Timeout;
    logic       o_Overrun;
    logic       o_Busy;

    uart_frame_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CLKS(TIMEOUT_CLKS),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Rst        (i_Rst),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Wr_En      (o_Wr_En),
        .o_Wr_Addr    (o_Wr_Addr),
        .o_Wr_Data    (o_Wr_Data),
        .i_Wr_Ready   (i_Wr_Ready),
        .o_Frame_Done (o_Frame_Done),
        .o_Err_Csum   (o_Err_Csum),
        .o_Err_Len    (o_Err_Len),
        .o_Err_Timeout(o_Err_Timeout),
        .o_Overrun    (o_Overrun),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [7:0]       nbytes;
        logic [23:0][7:0] bytes;
        logic             exp_done;
        logic             exp_csum;
        logic             exp_len;
    } vec_t;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  wq[$];
    int   accept_cycles[$];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int done_cnt = 0, csum_cnt = 0, len_cnt = 0, to_cnt = 0, ovr_cnt = 0, wr_cnt = 0, en_cycles = 0;
    int b_done, b_csum, b_len, b_to, b_ovr, b_wr, b_en;
    bit bp_mode = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge i_Clock); #1;
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(posedge i_Clock); #1;
        i_Rx_DV   = 1'b0;
    endtask

    function automatic void add_vec(input bq_t b, input logic d, input logic c, input logic l);
        vec_t v;
        v = '0;
        v.nbytes = 8'(b.size());
        foreach (b[i]) v.bytes[i] = b[i];
        v.exp_done = d;
        v.exp_csum = c;
        v.exp_len  = l;
        vecs.push_back(v);
    endfunction

    // Reference model: writes expected from a well-formed frame.
    function automatic int push_expected(input vec_t v);
        int s = 0;
        int n;
        logic [7:0] base;
        wr_t w;
        while (s < 20 && v.bytes[s] != 8'hA5) s++;
        base = v.bytes[s+1];
        n    = int'(v.bytes[s+2]);
        for (int i = 0; i < n; i++) begin
            w.addr = base + 8'(i);
            w.data = v.bytes[s+3+i];
            wq.push_back(w);
        end
        return n;
    endfunction

    task automatic snap();
        b_done = done_cnt; b_csum = csum_cnt; b_len = len_cnt; b_to = to_cnt;
        b_ovr = ovr_cnt; b_wr = wr_cnt; b_en = en_cycles;
    endtask

    task automatic check_deltas(input string tag, input int d, input int c, input int l,
                                input int t, input int o, input int w);
        checkOutput({tag, "_done"},     done_cnt - b_done, d);
        checkOutput({tag, "_err_csum"}, csum_cnt - b_csum, c);
        checkOutput({tag, "_err_len"},  len_cnt - b_len, l);
        checkOutput({tag, "_timeout"},  to_cnt - b_to, t);
        checkOutput({tag, "_overrun"},  ovr_cnt - b_ovr, o);
        checkOutput({tag, "_writes"},   wr_cnt - b_wr, w);
        checkOutput({tag, "_busy"},     int'(o_Busy), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_Busy || wq.size() != 0) && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        checks++;
        if (o_Busy || wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_wait: busy=%0d pending=%0d, expected busy=0 pending=0", o_Busy, wq.size());
        end
        repeat (2) @(negedge i_Clock);
    endtask

    // Scoreboard monitor: every cycle with a write request must match the queue head.
    initial begin
        forever begin
            @(negedge i_Clock);
            cycle++;
            if (o_Frame_Done)  done_cnt++;
            if (o_Err_Csum)    csum_cnt++;
            if (o_Err_Len)     len_cnt++;
            if (o_Err_Timeout) to_cnt++;
            if (o_Overrun)     ovr_cnt++;
            if (o_Wr_En) begin
                en_cycles++;
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", o_Wr_Addr, o_Wr_Data);
                end else begin
                    checkOutput("wr_addr", int'(o_Wr_Addr), int'(wq[0].addr));
                    checkOutput("wr_data", int'(o_Wr_Data), int'(wq[0].data));
                    if (i_Wr_Ready) begin
                        void'(wq.pop_front());
                        wr_cnt++;
                        accept_cycles.push_back(cycle);
                    end
                end
            end
        end
    end

    // Sink model: always ready, or 5 low cycles before accepting each write.
    initial begin
        int hold;
        hold = 0;
        i_Wr_Ready = 1'b1;
        forever begin
            @(posedge i_Clock); #1;
            if (!bp_mode) begin
                i_Wr_Ready = 1'b1;
                hold = 0;
            end else if (!o_Wr_En) begin
                i_Wr_Ready = 1'b0;
                hold = 0;
            end else if (i_Wr_Ready) begin
                i_Wr_Ready = 1'b0;
                hold = 1;
            end else if (hold >= 5) begin
                i_Wr_Ready = 1'b1;
            end else begin
                hold++;
            end
        end
    end

    initial begin
        bq_t t;
        logic [7:0] cs;
        logic [7:0] p;
        int nexp;
        int n;

        i_Rst = 1'b1;
        i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'h00;

        t = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}; add_vec(t, 1, 0, 0);
        t = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14}; add_vec(t, 0, 1, 0);
        t = '{8'hA5, 8'h10, 8'h00};                             add_vec(t, 0, 0, 1);
        t = '{8'hA5, 8'h10, 8'h11};                             add_vec(t, 0, 0, 1);
        t = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h01, 8'h5A, 8'h7B}; add_vec(t, 1, 0, 0);
        t = '{8'hA5, 8'hA5, 8'h02, 8'h01, 8'h02, 8'hA4};        add_vec(t, 1, 0, 0);
        t = '{8'hA5, 8'hF8, 8'h10};
        cs = 8'hF8 ^ 8'h10;
        for (int i = 0; i < MAX_LEN; i++) begin
            p = 8'(i * 17 + 3);
            t.push_back(p);
            cs ^= p;
        end
        t.push_back(cs);
        add_vec(t, 1, 0, 0);

        repeat (3) @(posedge i_Clock);
        #1;
        checkOutput("rst_wr_en",   int'(o_Wr_En), 0);
        checkOutput("rst_busy",    int'(o_Busy), 0);
        checkOutput("rst_done",    int'(o_Frame_Done), 0);
        checkOutput("rst_errs",    int'({o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Overrun}), 0);
        checkOutput("rst_addr",    int'(o_Wr_Addr), 0);
        i_Rst = 1'b0;
        repeat (2) @(posedge i_Clock);

        foreach (vecs[k]) begin
            snap();
            accept_cycles.delete();
            nexp = vecs[k].exp_done ? push_expected(vecs[k]) : 0;
            for (int i = 0; i < int'(vecs[k].nbytes); i++) begin
                applyStimulus(vecs[k].bytes[i]);
                repeat (2) @(posedge i_Clock);
            end
            wait_idle(200);
            check_deltas($sformatf("vec%0d", k), int'(vecs[k].exp_done), int'(vecs[k].exp_csum),
                         int'(vecs[k].exp_len), 0, 0, nexp);
            for (int i = 1; i < accept_cycles.size(); i++)
                checkOutput($sformatf("vec%0d_consecutive", k), accept_cycles[i] - accept_cycles[i-1], 1);
        end

        // Backpressure with address wrap, plus bytes (one of them SYNC) arriving mid-drain.
        bp_mode = 1'b1;
        snap();
        t = '{8'hA5, 8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h20};
        add_vec(t, 1, 0, 0);
        nexp = push_expected(vecs[vecs.size()-1]);
        foreach (t[i]) applyStimulus(t[i]);
        n = 0;
        while (!o_Wr_En && n < 50) begin
            @(negedge i_Clock);
            n++;
        end
        checkOutput("bp_drain_started", int'(o_Wr_En), 1);
        applyStimulus(8'hA5);
        applyStimulus(8'h33);
        wait_idle(200);
        check_deltas("bp", 1, 0, 0, 0, 2, nexp);
        checkOutput("bp_en_cycles", en_cycles - b_en, 18);
        bp_mode = 1'b0;
        repeat (3) @(posedge i_Clock);

        // Byte arriving on the same cycle as the final write accept.
        snap();
        wq.push_back(wr_t'({8'h40, 8'h77}));
        applyStimulus(8'hA5);
        applyStimulus(8'h40);
        applyStimulus(8'h01);
        applyStimulus(8'h77);
        @(posedge i_Clock); #1;
        i_Rx_DV = 1'b1;
        i_Rx_Byte = 8'h36;
        @(posedge i_Clock); #1;
        i_Rx_Byte = 8'hA5;
        @(posedge i_Clock); #1;
        i_Rx_DV = 1'b0;
        checkOutput("last_accept_overrun", int'(o_Overrun), 1);
        checkOutput("last_accept_done",    int'(o_Frame_Done), 1);
        checkOutput("last_accept_busy",    int'(o_Busy), 0);
        wait_idle(50);
        check_deltas("last_accept", 1, 0, 0, 0, 1, 1);

        // Reset in the middle of the payload abandons the frame.
        snap();
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        checkOutput("mid_payload_busy", int'(o_Busy), 1);
        @(posedge i_Clock); #1;
        i_Rst = 1'b1;
        @(posedge i_Clock); #1;
        checkOutput("mid_rst_outputs", int'({o_Wr_En, o_Frame_Done, o_Err_Csum, o_Err_Len,
                                             o_Err_Timeout, o_Overrun, o_Busy}), 0);
        i_Rst = 1'b0;
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h13);
        repeat (5) @(negedge i_Clock);
        check_deltas("post_rst", 0, 0, 0, 0, 0, 0);

        // Silence after ADDR: timeout fires exactly TIMEOUT_CLKS clocks after the last byte.
        snap();
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        repeat (TIMEOUT_CLKS - 1) @(posedge i_Clock);
        @(negedge i_Clock);
        checkOutput("timeout_early", int'(o_Err_Timeout), 0);
        checkOutput("timeout_busy_before", int'(o_Busy), 1);
        @(negedge i_Clock);
        checkOutput("timeout_pulse", int'(o_Err_Timeout), 1);
        checkOutput("timeout_busy_after", int'(o_Busy), 0);
        repeat (2) @(negedge i_Clock);
        check_deltas("timeout", 0, 0, 0, 1, 0, 0);

        // A byte arriving TIMEOUT_CLKS-1 clocks after the previous one keeps the frame alive.
        snap();
        wq.push_back(wr_t'({8'h10, 8'h5A}));
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        repeat (TIMEOUT_CLKS - 3) @(posedge i_Clock);
        applyStimulus(8'h01);
        applyStimulus(8'h5A);
        applyStimulus(8'h4B);
        wait_idle(50);
        check_deltas("keepalive", 1, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
